// File: rtl/rnn_mem_pkg.sv
// Shared constants and types for the RNN memory-port arbiter:
// msel code map, owner tags and bus widths.
package rnn_mem_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 20;
  localparam int SEL_W  = 3;

  localparam logic [SEL_W-1:0] SEL_W_HH = 3'b000;
  localparam logic [SEL_W-1:0] SEL_B    = 3'b001;
  localparam logic [SEL_W-1:0] SEL_W_IH = 3'b010;
  localparam logic [SEL_W-1:0] SEL_X    = 3'b011;
  localparam logic [SEL_W-1:0] SEL_IDLE = 3'b100;
  localparam logic [SEL_W-1:0] SEL_WR   = 3'b101;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

  // Codes 110 and 111 have no bank behind them.
  function automatic logic sel_is_illegal(input logic [SEL_W-1:0] sel);
    return (sel[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/rnn_mem_arbiter_if.sv
// Requester and memory-side signals of the RNN memory arbiter.
// slave = arbiter view, master = requesters plus memory macro.
interface rnn_mem_arbiter_if;
  import rnn_mem_pkg::*;

  logic              core_req;
  logic              core_lock;
  logic [SEL_W-1:0]  core_sel;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_rvalid;

  logic              host_req;
  logic [SEL_W-1:0]  host_sel;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic              host_err;

  logic [DATA_W-1:0] rdata;
  logic              mce;
  logic [SEL_W-1:0]  msel;
  logic [ADDR_W-1:0] maddr;
  logic [DATA_W-1:0] mdata_w;
  logic [DATA_W-1:0] mdata_r;

  modport slave (
    input  core_req, core_lock, core_sel, core_addr, core_wdata,
    input  host_req, host_sel, host_addr, host_wdata, mdata_r,
    output core_gnt, core_rvalid, host_gnt, host_rvalid, host_err,
    output rdata, mce, msel, maddr, mdata_w
  );

  modport master (
    output core_req, core_lock, core_sel, core_addr, core_wdata,
    output host_req, host_sel, host_addr, host_wdata, mdata_r,
    input  core_gnt, core_rvalid, host_gnt, host_rvalid, host_err,
    input  rdata, mce, msel, maddr, mdata_w
  );

endinterface

// File: rtl/rnn_rd_tag_pipe.sv
// Delay line of {valid, owner} tags matching the memory read latency.
module rnn_rd_tag_pipe
  import rnn_mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t r_pipe [DEPTH];

  // Shift tags one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_tag = r_pipe[DEPTH-1];

endmodule

// File: rtl/rnn_mem_arbiter.sv
// Two-port arbiter for the banked RNN memory: core has fixed priority,
// the host loader is protected by a starvation counter.
module rnn_mem_arbiter
  import rnn_mem_pkg::*;
#(
  parameter int               RD_LAT       = 1,
  parameter int               STARVE_LIMIT = 16,
  parameter logic [SEL_W-1:0] WR_SEL       = SEL_WR,
  parameter logic [SEL_W-1:0] IDLE_SEL     = SEL_IDLE
) (
  input logic               clk,
  input logic               reset,
  rnn_mem_arbiter_if.slave  bus
);

  localparam logic [7:0] WAIT_MAX = 8'(STARVE_LIMIT);

  logic              w_core_gnt;
  logic              w_host_gnt;
  logic              w_host_bad;
  logic [7:0]        r_wait;
  logic              r_mce;
  logic [SEL_W-1:0]  r_msel;
  logic [ADDR_W-1:0] r_maddr;
  logic [DATA_W-1:0] r_mdata_w;
  logic              r_host_err;
  owner_e            r_owner;
  rd_tag_t           w_push;
  rd_tag_t           w_pop;

  // A held lock beats the starvation override; grants are suppressed in reset.
  always_comb begin
    w_core_gnt = 1'b0;
    w_host_gnt = 1'b0;
    if (reset) begin
      if (bus.core_req && bus.core_lock) begin
        w_core_gnt = 1'b1;
      end else if (bus.host_req && (r_wait == WAIT_MAX)) begin
        w_host_gnt = 1'b1;
      end else if (bus.core_req) begin
        w_core_gnt = 1'b1;
      end else if (bus.host_req) begin
        w_host_gnt = 1'b1;
      end else begin
        w_core_gnt = 1'b0;
        w_host_gnt = 1'b0;
      end
    end else begin
      w_core_gnt = 1'b0;
      w_host_gnt = 1'b0;
    end
  end

  assign w_host_bad = w_host_gnt && sel_is_illegal(bus.host_sel);

  // Host wait counter: saturates, cleared by a grant or a dropped request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait <= 8'd0;
    end else if (!bus.host_req || w_host_gnt) begin
      r_wait <= 8'd0;
    end else if (r_wait != WAIT_MAX) begin
      r_wait <= r_wait + 8'd1;
    end else begin
      r_wait <= r_wait;
    end
  end

  // Memory pins: a rejected host request leaves the port idle, address/data held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mce      <= 1'b0;
      r_msel     <= IDLE_SEL;
      r_maddr    <= '0;
      r_mdata_w  <= '0;
      r_owner    <= OWN_CORE;
      r_host_err <= 1'b0;
    end else begin
      r_host_err <= w_host_bad;
      if (w_core_gnt) begin
        r_mce     <= 1'b1;
        r_msel    <= bus.core_sel;
        r_maddr   <= bus.core_addr;
        r_mdata_w <= bus.core_wdata;
        r_owner   <= OWN_CORE;
      end else if (w_host_gnt && !w_host_bad) begin
        r_mce     <= 1'b1;
        r_msel    <= bus.host_sel;
        r_maddr   <= bus.host_addr;
        r_mdata_w <= bus.host_wdata;
        r_owner   <= OWN_HOST;
      end else begin
        r_mce     <= 1'b0;
        r_msel    <= IDLE_SEL;
        r_maddr   <= r_maddr;
        r_mdata_w <= r_mdata_w;
        r_owner   <= r_owner;
      end
    end
  end

  // The tag enters the pipe while the access is on the pins.
  assign w_push.valid = r_mce && (r_msel != WR_SEL) && !sel_is_illegal(r_msel);
  assign w_push.owner = r_owner;

  rnn_rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .i_tag (w_push),
    .o_tag (w_pop)
  );

  assign bus.core_gnt    = w_core_gnt;
  assign bus.host_gnt    = w_host_gnt;
  assign bus.core_rvalid = w_pop.valid && (w_pop.owner == OWN_CORE);
  assign bus.host_rvalid = w_pop.valid && (w_pop.owner == OWN_HOST);
  assign bus.host_err    = r_host_err;
  assign bus.rdata       = bus.mdata_r;
  assign bus.mce         = r_mce;
  assign bus.msel        = r_msel;
  assign bus.maddr       = r_maddr;
  assign bus.mdata_w     = r_mdata_w;

endmodule

// File: tb/tb_rnn_mem_arbiter.sv
// Bench for rnn_mem_arbiter: two instances (read latency 1 and 3) share one
// stimulus stream and are checked against a queue-based reference model.
module tb_rnn_mem_arbiter;
  import rnn_mem_pkg::*;

  localparam int LIMIT = 16;

  typedef struct {
    int due;
    bit own;
  } rd_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_lock, host_req;
  logic [2:0]  core_sel, host_sel;
  logic [16:0] core_addr, host_addr;
  logic [19:0] core_wdata, host_wdata, mdata_r;

  rnn_mem_arbiter_if if1 ();
  rnn_mem_arbiter_if if3 ();

  assign if1.core_req = core_req;     assign if3.core_req = core_req;
  assign if1.core_lock = core_lock;   assign if3.core_lock = core_lock;
  assign if1.core_sel = core_sel;     assign if3.core_sel = core_sel;
  assign if1.core_addr = core_addr;   assign if3.core_addr = core_addr;
  assign if1.core_wdata = core_wdata; assign if3.core_wdata = core_wdata;
  assign if1.host_req = host_req;     assign if3.host_req = host_req;
  assign if1.host_sel = host_sel;     assign if3.host_sel = host_sel;
  assign if1.host_addr = host_addr;   assign if3.host_addr = host_addr;
  assign if1.host_wdata = host_wdata; assign if3.host_wdata = host_wdata;
  assign if1.mdata_r = mdata_r;       assign if3.mdata_r = mdata_r;

  rnn_mem_arbiter #(.RD_LAT(1), .STARVE_LIMIT(LIMIT)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  rnn_mem_arbiter #(.RD_LAT(3), .STARVE_LIMIT(LIMIT)) u_dut3 (.clk(clk), .reset(reset), .bus(if3));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // reference model state
  int          m_wait;
  logic        m_mce, m_err;
  logic [2:0]  m_msel;
  logic [16:0] m_maddr;
  logic [19:0] m_mdata_w;
  rd_t         q1[$];
  rd_t         q3[$];

  // last observed values (sampled mid-cycle inside tick)
  logic o_cg, o_hg, o_mce, o_err, o_crv1, o_hrv1, o_crv3, o_hrv3;
  logic [2:0]  o_msel;
  logic [16:0] o_maddr;
  logic [19:0] o_mdw, o_rd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string n, input logic cg, input logic hg, input logic mce,
                           input logic [2:0] msel, input logic [16:0] maddr, input logic [19:0] mdw,
                           input logic err, input logic crv, input logic hrv, input logic [19:0] rd,
                           input bit ecg, input bit ehg, input bit ecrv, input bit ehrv);
    chk({n, ".core_gnt"}, 32'(cg), 32'(ecg));
    chk({n, ".host_gnt"}, 32'(hg), 32'(ehg));
    chk({n, ".mce"}, 32'(mce), 32'(m_mce));
    chk({n, ".msel"}, 32'(msel), 32'(m_msel));
    chk({n, ".maddr"}, 32'(maddr), 32'(m_maddr));
    chk({n, ".mdata_w"}, 32'(mdw), 32'(m_mdata_w));
    chk({n, ".host_err"}, 32'(err), 32'(m_err));
    chk({n, ".core_rvalid"}, 32'(crv), 32'(ecrv));
    chk({n, ".host_rvalid"}, 32'(hrv), 32'(ehrv));
    if (ecrv || ehrv) chk({n, ".rdata"}, 32'(rd), 32'(mdata_r));
  endtask

  // One clock: check both DUTs mid-cycle, advance the model, move to next cycle.
  task automatic tick();
    bit cg, hg, e1c, e1h, e3c, e3h, rd_acc, issued, own;
    @(negedge clk);
    if (!reset) begin
      m_wait = 0; m_mce = 1'b0; m_msel = SEL_IDLE; m_maddr = '0; m_mdata_w = '0; m_err = 1'b0;
      q1.delete(); q3.delete();
    end
    cg = 1'b0; hg = 1'b0;
    if (reset) begin
      if (core_req && core_lock) cg = 1'b1;
      else if (host_req && m_wait == LIMIT) hg = 1'b1;
      else if (core_req) cg = 1'b1;
      else if (host_req) hg = 1'b1;
    end
    e1c = 1'b0; e1h = 1'b0; e3c = 1'b0; e3h = 1'b0;
    if (q1.size() > 0 && q1[0].due == cyc) begin e1h = q1[0].own; e1c = !q1[0].own; void'(q1.pop_front()); end
    if (q3.size() > 0 && q3[0].due == cyc) begin e3h = q3[0].own; e3c = !q3[0].own; void'(q3.pop_front()); end
    check_dut("lat1", if1.core_gnt, if1.host_gnt, if1.mce, if1.msel, if1.maddr, if1.mdata_w,
              if1.host_err, if1.core_rvalid, if1.host_rvalid, if1.rdata, cg, hg, e1c, e1h);
    check_dut("lat3", if3.core_gnt, if3.host_gnt, if3.mce, if3.msel, if3.maddr, if3.mdata_w,
              if3.host_err, if3.core_rvalid, if3.host_rvalid, if3.rdata, cg, hg, e3c, e3h);
    o_cg = if1.core_gnt; o_hg = if1.host_gnt; o_mce = if1.mce; o_msel = if1.msel;
    o_maddr = if1.maddr; o_mdw = if1.mdata_w; o_err = if1.host_err; o_rd1 = if1.rdata;
    o_crv1 = if1.core_rvalid; o_hrv1 = if1.host_rvalid; o_crv3 = if3.core_rvalid; o_hrv3 = if3.host_rvalid;
    if (reset) begin
      m_err = hg && (host_sel == 3'b110 || host_sel == 3'b111);
      issued = 1'b1; own = 1'b0; rd_acc = 1'b0;
      if (cg) begin
        m_msel = core_sel; m_maddr = core_addr; m_mdata_w = core_wdata;
      end else if (hg && !m_err) begin
        m_msel = host_sel; m_maddr = host_addr; m_mdata_w = host_wdata; own = 1'b1;
      end else begin
        issued = 1'b0; m_msel = SEL_IDLE;
      end
      m_mce = issued;
      if (issued) rd_acc = (m_msel != SEL_WR) && (m_msel != 3'b110) && (m_msel != 3'b111);
      if (rd_acc) begin
        q1.push_back('{cyc + 2, own});
        q3.push_back('{cyc + 4, own});
      end
      if (!host_req || hg) m_wait = 0;
      else if (m_wait < LIMIT) m_wait++;
    end
    cyc++;
    @(posedge clk);
    #1;
    mdata_r = 20'($urandom);
  endtask

  initial begin
    reset = 1'b0;
    core_req = 1'b0; core_lock = 1'b0; core_sel = 3'b000; core_addr = '0; core_wdata = '0;
    host_req = 1'b0; host_sel = 3'b000; host_addr = '0; host_wdata = '0; mdata_r = '0;
    m_wait = 0; m_mce = 1'b0; m_msel = SEL_IDLE; m_maddr = '0; m_mdata_w = '0; m_err = 1'b0;

    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("idle_mce", 32'(o_mce), 32'd0);
    chk("idle_msel", 32'(o_msel), 32'h4);
    chk("idle_gnt", 32'({o_cg, o_hg}), 32'd0);
    chk("idle_rvalid", 32'({o_crv1, o_hrv1, o_crv3, o_hrv3}), 32'd0);

    // core read issued at cycle 10
    while (cyc < 10) tick();
    core_req = 1'b1; core_sel = SEL_W_HH; core_addr = 17'h00021;
    tick();
    chk("rd_core_gnt", 32'(o_cg), 32'd1);
    core_req = 1'b0;
    tick();
    chk("rd_mce", 32'(o_mce), 32'd1);
    chk("rd_msel", 32'(o_msel), 32'h0);
    chk("rd_maddr", 32'(o_maddr), 32'h21);
    mdata_r = 20'h7FFFF;
    tick();
    chk("rd_rvalid", 32'(o_crv1), 32'd1);
    chk("rd_rdata", 32'(o_rd1), 32'h7FFFF);
    repeat (4) tick();

    // both requesting every cycle without lock
    core_req = 1'b1; core_sel = SEL_X; host_req = 1'b1; host_sel = SEL_B;
    for (int i = 0; i < 18; i++) begin
      core_addr = 17'($urandom); host_addr = 17'($urandom);
      tick();
      chk("starve_core_gnt", 32'(o_cg), (i == 16) ? 32'd0 : 32'd1);
      chk("starve_host_gnt", 32'(o_hg), (i == 16) ? 32'd1 : 32'd0);
    end
    core_req = 1'b0; host_req = 1'b0;
    tick();

    // same traffic under a 40-cycle core lock
    core_req = 1'b1; core_lock = 1'b1; host_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("lock_host_gnt", 32'(o_hg), 32'd0);
    end
    core_lock = 1'b0;
    tick();
    chk("unlock_host_gnt", 32'(o_hg), 32'd1);
    core_req = 1'b0; host_req = 1'b0;
    repeat (5) tick();

    // host write
    host_req = 1'b1; host_sel = SEL_WR; host_addr = 17'h0403F; host_wdata = 20'h10000;
    tick();
    chk("wr_host_gnt", 32'(o_hg), 32'd1);
    host_req = 1'b0;
    tick();
    chk("wr_mce", 32'(o_mce), 32'd1);
    chk("wr_msel", 32'(o_msel), 32'h5);
    chk("wr_maddr", 32'(o_maddr), 32'h0403F);
    chk("wr_mdata_w", 32'(o_mdw), 32'h10000);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wr_no_rvalid", 32'({o_hrv1, o_hrv3}), 32'd0);
    end

    // host illegal sel
    host_req = 1'b1; host_sel = 3'b110;
    tick();
    chk("bad_host_gnt", 32'(o_hg), 32'd1);
    host_req = 1'b0;
    tick();
    chk("bad_mce", 32'(o_mce), 32'd0);
    chk("bad_err", 32'(o_err), 32'd1);
    tick();
    chk("bad_err_pulse", 32'(o_err), 32'd0);

    // random interleaved traffic, requests held until granted
    for (int i = 0; i < 400; i++) begin
      if (!core_req || o_cg) begin
        core_req = ($urandom_range(0, 3) != 0);
        core_sel = ($urandom_range(0, 4) == 0) ? SEL_WR : 3'($urandom_range(0, 3));
        core_addr = 17'($urandom); core_wdata = 20'($urandom);
      end
      core_lock = ($urandom_range(0, 7) == 0);
      if (!host_req || o_hg) begin
        host_req = ($urandom_range(0, 1) != 0);
        host_sel = 3'($urandom_range(0, 7));
        host_addr = 17'($urandom); host_wdata = 20'($urandom);
      end
      tick();
    end
    core_req = 1'b0; host_req = 1'b0; core_lock = 1'b0;
    repeat (6) tick();

    // reset with three reads in flight
    core_req = 1'b1; core_sel = SEL_W_IH;
    repeat (3) tick();
    reset = 1'b0; core_req = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst_no_rvalid", 32'({o_crv1, o_hrv1, o_crv3, o_hrv3}), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
